pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Parametrised program-counter sequencer; successor of the 12-bit increment/load PC.
- Adds relative branch, call/return through an internal return-address stack, a configurable reset vector and a sticky stack-error flag.
- Sits at the fetch stage and drives the instruction-memory address; the control unit supplies one-hot operation strobes and D.
- All state changes take effect on the clock edge after the strobe (1-cycle latency).

Parameters:
PC_W, 12, width of PC, D and stack entries
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_VEC, 0, PC value loaded on reset (PC_W bits)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
hold  input  1  freeze: no PC, stack or error update while high
increment  input  1  PC <= PC+1
load  input  1  PC <= D (absolute jump)
branch  input  1  PC <= PC + signed(D)
call  input  1  push PC+1, PC <= D
ret  input  1  PC <= popped address
D  input  PC_W  jump target / two's-complement branch offset
Q  output  PC_W  current PC (registered)
sp  output  $clog2(STACK_DEPTH+1)  number of valid stack entries
stack_empty  output  1  sp==0
stack_full  output  1  sp==STACK_DEPTH
stack_err  output  1  sticky: call-on-full or ret-on-empty occurred

Behaviour:
- Reset: rst high at a clock edge sets Q=RESET_VEC, sp=0, stack_empty=1, stack_full=0, stack_err=0. Reset overrides hold and all strobes. Stack contents are don't-care after reset.
- hold=1 (rst=0): all state holds, whatever strobes are asserted.
- Priority when several strobes are high: ret > call > load > branch > increment. Only the winner acts.
- No strobe: Q unchanged.
- All PC arithmetic is modulo 2^PC_W and wraps silently. Examples: increment at all-ones gives 0; branch wraps in both directions.
- branch: offset is D taken as signed PC_W; target is current Q + D. D=all-ones therefore means Q-1.
- call, stack not full: stack[sp] <= Q+1 (wrapped); sp <= sp+1; Q <= D.
- call, stack full: Q, sp and stack unchanged; stack_err <= 1.
- ret, stack not empty: Q <= stack[sp-1]; sp <= sp-1.
- ret, stack empty: Q and sp unchanged; stack_err <= 1.
- stack_err clears only on rst.
- stack_empty and stack_full are combinational decodes of registered sp, so they are valid in the same cycle as sp.
- Output timing: Q and sp are registered with no combinational path from inputs to outputs. The new value is visible one cycle after the strobe.
- Back-to-back call/ret on consecutive cycles is fully supported. A ret directly after a call returns to call-site+1.

Decomposition:
- Package pc_seq_pkg holds:
  - the priority-ordered op enum (OP_NONE, OP_INC, OP_BRANCH, OP_LOAD, OP_CALL, OP_RET);
  - the strobe-to-op priority encoder function.
- Sub-module pc_ret_stack, parametrised by PC_W and STACK_DEPTH:
  - register-array LIFO with push/pop, sp, full and empty;
  - synchronous reset of sp only;
  - it ignores push-when-full and pop-when-empty, and pc_sequencer raises the error.
- pc_sequencer contains the op decode, the PC register and the error flag.

Test Plan:
- Test configuration: PC_W=12, STACK_DEPTH=4, RESET_VEC=12'h100.
- Reset, then increment for 3 cycles, then hold=1 with increment=1 for 2 cycles -> Q=100,101,102,103,103,103; sp=0; stack_err=0.
- load D=FFE, then increment x3 -> Q=FFE,FFF,000,001 (wraparound).
- From Q=010: branch D=005 -> Q=015; then branch D=FFB (-5) -> Q=010. From Q=002: branch D=FFC -> Q=FFE.
- Nested calls:
  - from Q=020, call D=200, call D=300, call D=400, call D=500 -> sp=4, stack_full=1;
  - a 5th call D=600 -> Q=500, sp=4, stack_err=1;
  - then ret x4 -> Q=401,301,201,021; stack_empty=1.
- ret on empty at Q=050 -> Q=050, stack_err=1; a later rst clears stack_err=0 and sets Q=100.
- Simultaneous strobes:
  - ret+call+load with sp=1, top=0AB -> Q=0AB, sp=0;
  - load+branch+increment with D=123 -> Q=123;
  - rst asserted during a call -> Q=100, sp=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// Holds the priority-ordered operation enum and the function that
// reduces the one-hot strobes to the single winning operation.
package pc_seq_pkg;

  // Listed from lowest to highest priority.
  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_INC    = 3'd1,
    OP_BRANCH = 3'd2,
    OP_LOAD   = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5
  } pc_op_e;

  // Priority encoder: ret > call > load > branch > increment.
  function automatic pc_op_e decode_op(
    input logic increment,
    input logic load,
    input logic branch,
    input logic call,
    input logic ret
  );
    pc_op_e op;
    op = OP_NONE;
    if (ret)            op = OP_RET;
    else if (call)      op = OP_CALL;
    else if (load)      op = OP_LOAD;
    else if (branch)    op = OP_BRANCH;
    else if (increment) op = OP_INC;
    return op;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for the program-counter sequencer.
// A small register array with a stack pointer counting valid entries.
// Push on full and pop on empty are silently ignored; the parent
// decides whether that is an error. Only the pointer is reset, the
// entries themselves keep whatever they held.
module pc_ret_stack
  import pc_seq_pkg::*;
#(
  parameter int PC_W        = 12,
  parameter int STACK_DEPTH = 4,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1),
  localparam int IDX_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty
);

  logic [PC_W-1:0] mem [STACK_DEPTH];
  logic [SP_W-1:0] top_sp;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  // The pointer counts entries, so the next free slot is sp and the
  // most recent entry is sp-1; both fit the array index once the
  // out-of-range cases (full push, empty pop) are excluded.
  always_comb begin
    full   = (sp == SP_W'(STACK_DEPTH));
    empty  = (sp == '0);
    top_sp = sp - SP_W'(1);
    wr_idx = sp[IDX_W-1:0];
    rd_idx = top_sp[IDX_W-1:0];
    top    = mem[rd_idx];
  end

  // Entry storage: write only on an accepted push.
  always_ff @(posedge clk) begin
    if (!rst && push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

  // Stack pointer: push and pop never arrive together from the parent.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with increment, absolute load, relative
// branch and call/return through an internal return-address stack.
// One-hot strobes from the control unit are reduced to a single
// operation; every change lands on the edge after the strobe.
// A sticky flag records any call on a full stack or ret on an empty one.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W        = 12,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC   = '0,
  localparam int             SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            increment,
  input  logic            load,
  input  logic            branch,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] D,
  output logic [PC_W-1:0] Q,
  output logic [SP_W-1:0] sp,
  output logic            stack_empty,
  output logic            stack_full,
  output logic            stack_err
);

  pc_op_e          op;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] ret_addr;
  logic [PC_W-1:0] next_seq;

  // Pick the winning strobe; hold suppresses any stack movement.
  always_comb begin
    op       = decode_op(increment, load, branch, call, ret);
    push     = !hold && (op == OP_CALL);
    pop      = !hold && (op == OP_RET);
    next_seq = Q + PC_W'(1);
  end

  pc_ret_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (next_seq),
    .top       (ret_addr),
    .sp        (sp),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  // PC register and sticky error flag; arithmetic wraps modulo 2^PC_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      Q         <= RESET_VEC;
      stack_err <= 1'b0;
    end else if (!hold) begin
      unique case (op)
        OP_INC:    Q <= next_seq;
        OP_BRANCH: Q <= Q + D;
        OP_LOAD:   Q <= D;
        OP_CALL: begin
          if (stack_full) stack_err <= 1'b1;
          else            Q <= D;
        end
        OP_RET: begin
          if (stack_empty) stack_err <= 1'b1;
          else             Q <= ret_addr;
        end
        default: Q <= Q;
      endcase
    end
  end

endmodule
